edge_detector_multi: RTL

Multi-channel, parametrised edge detector with a per-channel glitch filter, selectable edge polarity and saturating per-channel edge counters. Each channel runs a 4-state filter FSM, emits a one-cycle pulse on each qualified edge and counts those edges. It serves as the common input-event front end for the control blocks, in place of single-bit, single-polarity detectors.

---
 rtl/edge_detector_pkg.sv | 30 +++
 rtl/edge_filter_chan.sv | 91 +++++++++
 rtl/edge_detector_multi.sv | 70 +++++++
 3 files changed

// File: rtl/edge_detector_pkg.sv
// edge_detector_pkg: shared encodings for the multi-channel edge detector.
//   mode_e        : edge polarity select (rise / fall / both / off)
//   filt_state_e  : per-channel glitch-filter FSM states; bit 1 is the
//                   filtered level, bit 0 marks a pending transition.
//   rise_en/fall_en : decode which acceptances a mode turns into pulses.
package edge_detector_pkg;

   typedef enum logic [1:0] {
      MODE_RISE = 2'b00,
      MODE_FALL = 2'b01,
      MODE_BOTH = 2'b10,
      MODE_OFF  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      S_LOW       = 2'b00,
      S_LOW_PEND  = 2'b01,
      S_HIGH      = 2'b10,
      S_HIGH_PEND = 2'b11
   } filt_state_e;

   function automatic logic rise_en(input logic [1:0] m);
      return (m == MODE_RISE) || (m == MODE_BOTH);
   endfunction

   function automatic logic fall_en(input logic [1:0] m);
      return (m == MODE_FALL) || (m == MODE_BOTH);
   endfunction

endpackage

// File: rtl/edge_filter_chan.sv
// edge_filter_chan: one channel of the edge detector.
//   clock, reset : rising-edge clock, async active-high reset
//   d_in         : raw input bit, registered into d_s every cycle
//   mode         : polarity select, only looked at on the acceptance cycle
//   rise_acc     : registered one-cycle pulse on a qualified rising edge
//   fall_acc     : registered one-cycle pulse on a qualified falling edge
// The FSM needs FILTER_CYCLES consecutive d_s samples at the new level
// before the filtered level flips; any sample back at the old level
// abandons the pending change.
module edge_filter_chan
   import edge_detector_pkg::*;
#(
   parameter int FILTER_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       d_in,
   input  logic [1:0] mode,
   output logic       rise_acc,
   output logic       fall_acc
);

   localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [FW-1:0] FC_LAST = FW'(FILTER_CYCLES - 1);

   logic          d_s;
   filt_state_e   state;
   logic [FW-1:0] fcnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         d_s      <= 1'b0;
         state    <= S_LOW;
         fcnt     <= '0;
         rise_acc <= 1'b0;
         fall_acc <= 1'b0;
      end else begin
         d_s      <= d_in;
         rise_acc <= 1'b0;
         fall_acc <= 1'b0;
         case (state)
            S_LOW:
               if (d_s) begin
                  // A single-sample filter accepts on the first new sample.
                  if (FILTER_CYCLES == 1) begin
                     state    <= S_HIGH;
                     fcnt     <= '0;
                     rise_acc <= rise_en(mode);
                  end else begin
                     state <= S_LOW_PEND;
                     fcnt  <= FW'(1);
                  end
               end
            S_LOW_PEND:
               if (!d_s) begin
                  state <= S_LOW;
                  fcnt  <= '0;
               end else if (fcnt == FC_LAST) begin
                  state    <= S_HIGH;
                  fcnt     <= '0;
                  rise_acc <= rise_en(mode);
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
            S_HIGH:
               if (!d_s) begin
                  if (FILTER_CYCLES == 1) begin
                     state    <= S_LOW;
                     fcnt     <= '0;
                     fall_acc <= fall_en(mode);
                  end else begin
                     state <= S_HIGH_PEND;
                     fcnt  <= FW'(1);
                  end
               end
            S_HIGH_PEND:
               if (d_s) begin
                  state <= S_HIGH;
                  fcnt  <= '0;
               end else if (fcnt == FC_LAST) begin
                  state    <= S_LOW;
                  fcnt     <= '0;
                  fall_acc <= fall_en(mode);
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
         endcase
      end
   end

endmodule

// File: rtl/edge_detector_multi.sv
// edge_detector_multi: CHANNELS independent glitch-filtered edge detectors
// with polarity select and saturating per-channel edge counters.
//   clock, reset : rising-edge clock, async active-high reset
//   d_in         : raw inputs, one bit per channel
//   mode         : 00 rise, 01 fall, 10 both, 11 off (filters keep tracking)
//   count_clear  : synchronous clear of all counters and overflow flags
//   edge_pulse   : one-cycle pulse per qualified edge
//   any_edge     : OR of edge_pulse
//   edge_count   : channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   overflow     : sticky flag, set by an increment attempted at saturation
// Counters consume edge_pulse, so a count reflects a pulse one cycle after
// the pulse is shown; count_clear in the pulse cycle leaves the count at 1.
module edge_detector_multi
   import edge_detector_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int FILTER_CYCLES = 2,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           d_in,
   input  logic [1:0]                    mode,
   input  logic                          count_clear,
   output logic [CHANNELS-1:0]           edge_pulse,
   output logic                          any_edge,
   output logic [CHANNELS*CNT_WIDTH-1:0] edge_count,
   output logic [CHANNELS-1:0]           overflow
);

   logic [CHANNELS-1:0]                rise_acc;
   logic [CHANNELS-1:0]                fall_acc;
   logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      edge_filter_chan #(
         .FILTER_CYCLES(FILTER_CYCLES)
      ) u_chan (
         .clock    (clock),
         .reset    (reset),
         .d_in     (d_in[g]),
         .mode     (mode),
         .rise_acc (rise_acc[g]),
         .fall_acc (fall_acc[g])
      );
   end

   assign edge_pulse = rise_acc | fall_acc;
   assign any_edge   = |edge_pulse;
   assign edge_count = cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         overflow <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (count_clear) begin
               // The clearing cycle still counts its own pulse.
               cnt_q[i]    <= edge_pulse[i] ? CNT_WIDTH'(1) : '0;
               overflow[i] <= 1'b0;
            end else if (edge_pulse[i]) begin
               if (&cnt_q[i]) overflow[i] <= 1'b1;
               else           cnt_q[i]    <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

endmodule
